// File: rtl/main_dot_param.sv
// main_dot_param -- streaming, handshaked dot-product unit.
//
// Accepts DATA_N-lane signed data/weight beats, sums the lane products of
// CHUNKS consecutive beats into one accumulator, then scales the sum with an
// arithmetic right shift of FRAC_BITS, saturates it to BIT_LENGTH and stores
// it in the next of HID_LENGTH output slots. Filling the last slot pulses
// valid for one cycle and returns to IDLE.
//
// Ports:
//   clk, rst_n  clock; synchronous active-low reset
//   run         start pulse, honoured only in IDLE
//   in_valid    beat present on data_in / weight_in
//   in_ready    high in ACC; beat accepted on in_valid && in_ready
//   data_in     DATA_N*BIT_LENGTH, lane 0 in MSB slice
//   weight_in   DATA_N*BIT_LENGTH, paired lane-for-lane with data_in
//   busy        high in ACC
//   valid       one-cycle result pulse
//   data_out    HID_LENGTH*BIT_LENGTH, element 0 in MSB slice

// Single-lane signed product, sign-extended to the accumulator width.
module main_dot_param_lane #(
  parameter int B = 16,
  parameter int W = 40
) (
  input  logic [B-1:0] a,
  input  logic [B-1:0] b,
  output logic [W-1:0] p
);
  logic signed [2*B-1:0] prod;
  assign prod = $signed(a) * $signed(b);
  assign p    = W'(prod);
endmodule

module main_dot_param #(
  parameter int BIT_LENGTH = 16,
  parameter int DATA_N     = 6,
  parameter int HID_LENGTH = 24,
  parameter int CHUNKS     = 1,
  parameter int FRAC_BITS  = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             run,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_N*BIT_LENGTH-1:0]     data_in,
  input  logic [DATA_N*BIT_LENGTH-1:0]     weight_in,
  output logic                             busy,
  output logic                             valid,
  output logic [HID_LENGTH*BIT_LENGTH-1:0] data_out
);
  // Wide enough for DATA_N*CHUNKS full-precision products plus sign.
  localparam int ACC_W = 2*BIT_LENGTH + $clog2(DATA_N*CHUNKS) + 1;
  localparam int HW    = (HID_LENGTH > 1) ? $clog2(HID_LENGTH) : 1;
  localparam int BW    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-BIT_LENGTH+1){1'b0}}, {(BIT_LENGTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-BIT_LENGTH+1){1'b1}}, {(BIT_LENGTH-1){1'b0}}};

  typedef enum logic {IDLE, ACC} state_t;
  state_t state, state_nxt;

  logic signed [ACC_W-1:0]      acc;
  logic [BW-1:0]                beat_cnt;
  logic [HW-1:0]                hid_cnt;
  logic [BIT_LENGTH-1:0]        res [HID_LENGTH];

  logic [DATA_N-1:0][ACC_W-1:0] prod;
  logic signed [ACC_W-1:0]      psum, total, shifted;
  logic [BIT_LENGTH-1:0]        sat_val;
  logic                         accept, last_beat, last_slot;

  // Per-lane multipliers; lane 0 lives in the MSB slice of the beat.
  for (genvar i = 0; i < DATA_N; i++) begin : g_lane
    main_dot_param_lane #(.B(BIT_LENGTH), .W(ACC_W)) u_lane (
      .a (data_in  [(DATA_N-1-i)*BIT_LENGTH +: BIT_LENGTH]),
      .b (weight_in[(DATA_N-1-i)*BIT_LENGTH +: BIT_LENGTH]),
      .p (prod[i])
    );
  end

  always_comb begin
    psum = '0;
    for (int i = 0; i < DATA_N; i++) psum = psum + $signed(prod[i]);
  end

  assign total   = acc + psum;
  assign shifted = total >>> FRAC_BITS;

  always_comb begin
    sat_val = shifted[BIT_LENGTH-1:0];
    if (shifted > SAT_MAX)      sat_val = SAT_MAX[BIT_LENGTH-1:0];
    else if (shifted < SAT_MIN) sat_val = SAT_MIN[BIT_LENGTH-1:0];
  end

  assign in_ready  = (state == ACC);
  assign busy      = (state == ACC);
  assign accept    = in_valid && in_ready;
  assign last_beat = (beat_cnt == BW'(CHUNKS-1));
  assign last_slot = (hid_cnt == HW'(HID_LENGTH-1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = ACC;
      ACC:     if (accept && last_beat && last_slot) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      beat_cnt <= '0;
      hid_cnt  <= '0;
      valid    <= 1'b0;
      for (int k = 0; k < HID_LENGTH; k++) res[k] <= '0;
    end else begin
      state <= state_nxt;
      valid <= 1'b0;
      if (state == IDLE) begin
        if (run) begin
          acc      <= '0;
          beat_cnt <= '0;
          hid_cnt  <= '0;
          for (int k = 0; k < HID_LENGTH; k++) res[k] <= '0;
        end
      end else if (accept) begin
        if (!last_beat) begin
          acc      <= total;
          beat_cnt <= beat_cnt + 1'b1;
        end else begin
          res[hid_cnt] <= sat_val;
          acc          <= '0;
          beat_cnt     <= '0;
          if (last_slot) begin
            hid_cnt <= '0;
            valid   <= 1'b1;
          end else begin
            hid_cnt <= hid_cnt + 1'b1;
          end
        end
      end
    end
  end

  // Slot 0 (first computed) goes to the MSB slice.
  for (genvar k = 0; k < HID_LENGTH; k++) begin : g_out
    assign data_out[(HID_LENGTH-1-k)*BIT_LENGTH +: BIT_LENGTH] = res[k];
  end
endmodule

// File: tb/tb_main_dot_param.sv
module tb_main_dot_param;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        run = 1'b0;
  logic        in_valid = 1'b0;
  logic [95:0] data_in = '0;
  logic [95:0] weight_in = '0;

  // basic: HID=2 CHUNKS=1
  logic        rdy_b, busy_b, vld_b;
  logic [31:0] dout_b;
  // chunking: HID=1 CHUNKS=2
  logic        rdy_c, busy_c, vld_c;
  logic [15:0] dout_c;
  // saturation: HID=1 CHUNKS=1 FRAC=0
  logic        rdy_s, busy_s, vld_s;
  logic [15:0] dout_s;
  // fixed point: HID=1 CHUNKS=1 FRAC=8
  logic        rdy_f, busy_f, vld_f;
  logic [15:0] dout_f;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  main_dot_param #(.HID_LENGTH(2), .CHUNKS(1), .FRAC_BITS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .run(run), .in_valid(in_valid), .in_ready(rdy_b),
    .data_in(data_in), .weight_in(weight_in), .busy(busy_b), .valid(vld_b),
    .data_out(dout_b));
  main_dot_param #(.HID_LENGTH(1), .CHUNKS(2), .FRAC_BITS(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .run(run), .in_valid(in_valid), .in_ready(rdy_c),
    .data_in(data_in), .weight_in(weight_in), .busy(busy_c), .valid(vld_c),
    .data_out(dout_c));
  main_dot_param #(.HID_LENGTH(1), .CHUNKS(1), .FRAC_BITS(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .run(run), .in_valid(in_valid), .in_ready(rdy_s),
    .data_in(data_in), .weight_in(weight_in), .busy(busy_s), .valid(vld_s),
    .data_out(dout_s));
  main_dot_param #(.HID_LENGTH(1), .CHUNKS(1), .FRAC_BITS(8)) dut_f (
    .clk(clk), .rst_n(rst_n), .run(run), .in_valid(in_valid), .in_ready(rdy_f),
    .data_in(data_in), .weight_in(weight_in), .busy(busy_f), .valid(vld_f),
    .data_out(dout_f));

  function automatic logic [95:0] pack(input logic [15:0] l0, l1, l2, l3, l4, l5);
    return {l0, l1, l2, l3, l4, l5};
  endfunction

  // Drive just after the edge, so values are stable well before the next one.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat1();
    data_in   = pack(16'd3, 16'd5, 16'd1, 16'd5, 16'd8, 16'd9);
    weight_in = pack(16'd2, 16'd5, 16'd9, 16'd2, 16'd3, 16'd5);
  endtask

  task automatic set_beat2();
    data_in   = pack(16'd5, 16'd6, 16'd1, 16'd2, 16'd3, 16'd4);
    weight_in = pack(16'd2, 16'd2, 16'd4, 16'd5, 16'd1, 16'd2);
  endtask

  task automatic restart();
    in_valid = 1'b0; run = 1'b0;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    run = 1'b1; step(); run = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; step(); step(); rst_n = 1'b1;
    checks++; if (dout_b !== 32'h0) begin errors++; $display("FAIL reset_dout got=%h exp=%h", dout_b, 32'h0); end
    checks++; if ({vld_b, busy_b, rdy_b} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got=%b exp=000", {vld_b, busy_b, rdy_b}); end
  endtask

  task automatic test_basic();
    restart();
    checks++; if (rdy_b !== 1'b1) begin errors++; $display("FAIL basic_ready got=%b exp=1", rdy_b); end
    in_valid = 1'b1; set_beat1(); step();
    checks++; if (vld_b !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", vld_b); end
    checks++; if (vld_c !== 1'b0) begin errors++; $display("FAIL chunk_early_valid got=%b exp=0", vld_c); end
    set_beat2(); step();
    in_valid = 1'b0;
    checks++; if (vld_b !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", vld_b); end
    checks++; if (dout_b !== 32'h0077_002F) begin errors++; $display("FAIL basic_dout got=%h exp=%h", dout_b, 32'h0077_002F); end
    checks++; if (rdy_b !== 1'b0) begin errors++; $display("FAIL basic_ready_after got=%b exp=0", rdy_b); end
    checks++; if (vld_c !== 1'b1) begin errors++; $display("FAIL chunk_valid got=%b exp=1", vld_c); end
    checks++; if (dout_c !== 16'h00A6) begin errors++; $display("FAIL chunk_dout got=%h exp=%h", dout_c, 16'h00A6); end
    step();
    checks++; if (vld_b !== 1'b0) begin errors++; $display("FAIL basic_valid_one_cycle got=%b exp=0", vld_b); end
    checks++; if (dout_b !== 32'h0077_002F) begin errors++; $display("FAIL basic_hold got=%h exp=%h", dout_b, 32'h0077_002F); end
  endtask

  task automatic test_back_to_back();
    restart();
    in_valid = 1'b1; set_beat1(); step();
    set_beat2(); step();
    in_valid = 1'b0; run = 1'b1;   // run during the valid cycle
    checks++; if (vld_b !== 1'b1) begin errors++; $display("FAIL b2b_valid got=%b exp=1", vld_b); end
    step(); run = 1'b0;
    checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL b2b_busy got=%b exp=1", busy_b); end
    checks++; if (dout_b !== 32'h0) begin errors++; $display("FAIL b2b_clear got=%h exp=0", dout_b); end
  endtask

  task automatic test_saturation();
    restart();
    in_valid = 1'b1;
    data_in = {6{16'h7FFF}}; weight_in = {6{16'h7FFF}}; step(); in_valid = 1'b0;
    checks++; if (vld_s !== 1'b1) begin errors++; $display("FAIL sat_pos_valid got=%b exp=1", vld_s); end
    checks++; if (dout_s !== 16'h7FFF) begin errors++; $display("FAIL sat_pos got=%h exp=%h", dout_s, 16'h7FFF); end
    restart();
    in_valid = 1'b1;
    data_in = {6{16'h8000}}; weight_in = {6{16'h7FFF}}; step(); in_valid = 1'b0;
    checks++; if (dout_s !== 16'h8000) begin errors++; $display("FAIL sat_neg got=%h exp=%h", dout_s, 16'h8000); end
  endtask

  task automatic test_fixed_point();
    restart();
    in_valid = 1'b1;
    data_in = pack(16'h0180, 0, 0, 0, 0, 0); weight_in = pack(16'h0200, 0, 0, 0, 0, 0);
    step(); in_valid = 1'b0;
    checks++; if (dout_f !== 16'h0300) begin errors++; $display("FAIL frac_pos got=%h exp=%h", dout_f, 16'h0300); end
    restart();
    in_valid = 1'b1;
    data_in = pack(16'hFF80, 0, 0, 0, 0, 0); weight_in = pack(16'h0100, 0, 0, 0, 0, 0);
    step(); in_valid = 1'b0;
    checks++; if (dout_f !== 16'hFF80) begin errors++; $display("FAIL frac_neg got=%h exp=%h", dout_f, 16'hFF80); end
  endtask

  task automatic test_flow_control();
    int vcount;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    // Beats offered in IDLE (including the run edge) must be ignored.
    in_valid = 1'b1; set_beat2(); step(); step();
    checks++; if (rdy_b !== 1'b0) begin errors++; $display("FAIL flow_idle_ready got=%b exp=0", rdy_b); end
    run = 1'b1; step(); run = 1'b0;
    set_beat1(); step();
    in_valid = 1'b0;
    vcount = 0;
    for (int i = 0; i < 3; i++) begin step(); if (vld_b) vcount++; end
    checks++; if (vcount !== 0 || busy_b !== 1'b1) begin errors++; $display("FAIL flow_stall got=%0d/%b exp=0/1", vcount, busy_b); end
    in_valid = 1'b1; set_beat2(); step(); in_valid = 1'b0;
    checks++; if (vld_b !== 1'b1) begin errors++; $display("FAIL flow_valid got=%b exp=1", vld_b); end
    checks++; if (dout_b !== 32'h0077_002F) begin errors++; $display("FAIL flow_dout got=%h exp=%h", dout_b, 32'h0077_002F); end
  endtask

  task automatic test_reset_abort();
    int vcount;
    restart();
    in_valid = 1'b1; set_beat1(); step(); in_valid = 1'b0;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    checks++; if (dout_b !== 32'h0) begin errors++; $display("FAIL abort_dout got=%h exp=0", dout_b); end
    checks++; if ({vld_b, busy_b, rdy_b} !== 3'b000) begin errors++; $display("FAIL abort_ctrl got=%b exp=000", {vld_b, busy_b, rdy_b}); end
    in_valid = 1'b1; set_beat2(); step(); in_valid = 1'b0;
    vcount = vld_b ? 1 : 0;
    step(); if (vld_b) vcount++;
    checks++; if (vcount !== 0) begin errors++; $display("FAIL abort_no_valid got=%0d exp=0", vcount); end
    // run asserted mid-run must not restart the accumulation.
    restart();
    in_valid = 1'b1; set_beat1(); step();
    in_valid = 1'b0; run = 1'b1; step(); run = 1'b0;
    in_valid = 1'b1; set_beat2(); step(); in_valid = 1'b0;
    checks++; if (vld_b !== 1'b1) begin errors++; $display("FAIL runign_valid got=%b exp=1", vld_b); end
    checks++; if (dout_b !== 32'h0077_002F) begin errors++; $display("FAIL runign_dout got=%h exp=%h", dout_b, 32'h0077_002F); end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturation();
    test_fixed_point();
    test_flow_control();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
